rob_ring: RTL
=============

// Module: rob_ring
// PURPOSE
//  Parametrised reorder buffer: circular queue of in-flight instructions between dispatch and register file/memory.
//  Allocates tags in order, accepts out-of-order results from reservation stations, retires in order.
//  ALU results retire to the register file; stores retire through a memory handshake.
//  Speculative entries are truncated on branch-mispredict flush.
// PARAMETERS
//  DEPTH_LOG  4   log2 of entry count (DEPTH = 2**DEPTH_LOG)
//  XLEN       32  data/address width
//  REG_W      5   architectural register index width
// PORTS
//  clk           in   1          system clock
//  rst           in   1          synchronous active-high reset
//  rdy           in   1          global enable; low freezes all state
//  alloc_valid   in   1          dispatch requests an entry
//  alloc_is_st   in   1          entry is a store
//  alloc_rd      in   REG_W      destination register (ignored for stores)
//  alloc_ready   out  1          entry available (= !full)
//  alloc_tag     out  DEPTH_LOG  tag to be given to this allocation (tail index)
//  wb_valid      in   1          result writeback from RS/CDB
//  wb_tag        in   DEPTH_LOG  entry being completed
//  wb_value      in   XLEN       result value / store data
//  wb_addr       in   XLEN       store address (ignored for non-stores)
//  flush         in   1          discard entries from flush_tag to tail
//  flush_tag     in   DEPTH_LOG  first discarded tag
//  commit_valid  out  1          one-cycle register-file write pulse
//  commit_rd     out  REG_W      register written
//  commit_value  out  XLEN       value written
//  commit_tag    out  DEPTH_LOG  retiring tag (lets rename table clear its mapping)
//  st_req        out  1          store request to memory controller
//  st_addr       out  XLEN       store address
//  st_data       out  XLEN       store data
//  st_ack        in   1          memory controller accepted the store
//  empty         out  1          no live entries
//  full          out  1          DEPTH live entries
//  count         out  DEPTH_LOG+1  live entry count
// BEHAVIOUR
//  - Pointers: head/tail are DEPTH_LOG+1 bits with wrap bit.
//    count = tail - head; empty = (count == 0); full = (count == DEPTH).
//  - Reset: head = tail = 0; all done bits 0; state IDLE.
//    commit_valid = st_req = 0; commit_rd/value/tag = 0; st_addr/data = 0.
//  - rdy low: no state changes. commit_valid is forced 0. st_req and its payload hold.
//  - Alloc: fires on alloc_valid && alloc_ready. Writes rd/is_st, clears done, then tail++.
//    alloc_ready comes from registered full, so a same-cycle retire does not admit an alloc at full.
//  - Writeback: sets done for the live wb_tag and stores value, plus addr for stores.
//    Writeback to a non-live tag (flushed or retired) is ignored.
//    Earliest retire is the cycle after writeback.
//  - FSM IDLE: if head is live and done:
//    - non-store: commit_valid = 1 with rd/value/tag for one cycle; head++.
//    - store: st_req = 1, st_addr/st_data loaded; go to ST_WAIT.
//  - FSM ST_WAIT: hold st_req and payload until st_ack. On st_ack: st_req = 0, head++, return to IDLE.
//  - Retire rate is at most one entry per cycle; stores take at least 2 cycles.
//  - Flush: tail <= {wrap, flush_tag}, where wrap makes flush_tag lie in (head, tail].
//    Flush has priority over a same-cycle alloc (the alloc is dropped).
//    Flush never removes head: a store in ST_WAIT always completes.
//    flush_tag == tail index is a no-op.
//  - A same-cycle writeback and flush to a discarded tag is ignored.
// CONFIGURATION
//  ROB_OPERAND_FWD_EN defined:
//    - Adds 2 lookup ports: q{0,1}_tag in DEPTH_LOG; q{0,1}_hit out 1; q{0,1}_value out XLEN.
//    - Combinational: hit = tag live && done; value = stored result.
//    - Same-cycle wb_tag match also hits with wb_value (bypass).
//  Undefined: ports absent; operands come only from commit broadcast.
// TESTING
//  1. Reset, then 16 allocs -> alloc_tag 0..15, full = 1, count = 16, alloc_ready = 0.
//  2. Fill 3 entries; wb tags 2, 0, 1 with 0x22, 0x00, 0x11 -> commits in tag order 0, 1, 2
//     on consecutive cycles; first commit is the cycle after wb of tag 0.
//  3. Store at head, wb addr = 0x1000, data = 0xAB; hold st_ack low 4 cycles -> st_req held, payload stable;
//     ack -> head++ next cycle.
//  4. Allocate tags 0..5; flush with flush_tag = 3 -> count = 3, next alloc_tag = 3;
//     late wb on old tag 4 is ignored.
//  5. Fill to tail wrapping past 15 to 2; retire/realloc 40 entries -> count stays consistent.
//     Simultaneous alloc + commit leaves count unchanged.
//  6. rdy low during ST_WAIT with st_ack high -> no retire; resumes when rdy returns.

Source files
------------

// File: rtl/rob_ring.sv
// Reorder buffer: circular queue with in-order alloc/retire and out-of-order writeback.
// Optional operand lookup ports are enabled by defining ROB_OPERAND_FWD_EN.
module rob_ring #(
    parameter int DEPTH_LOG = 4,
    parameter int XLEN      = 32,
    parameter int REG_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 alloc_valid,
    input  logic                 alloc_is_st,
    input  logic [REG_W-1:0]     alloc_rd,
    output logic                 alloc_ready,
    output logic [DEPTH_LOG-1:0] alloc_tag,
    input  logic                 wb_valid,
    input  logic [DEPTH_LOG-1:0] wb_tag,
    input  logic [XLEN-1:0]      wb_value,
    input  logic [XLEN-1:0]      wb_addr,
    input  logic                 flush,
    input  logic [DEPTH_LOG-1:0] flush_tag,
    output logic                 commit_valid,
    output logic [REG_W-1:0]     commit_rd,
    output logic [XLEN-1:0]      commit_value,
    output logic [DEPTH_LOG-1:0] commit_tag,
    output logic                 st_req,
    output logic [XLEN-1:0]      st_addr,
    output logic [XLEN-1:0]      st_data,
    input  logic                 st_ack,
`ifdef ROB_OPERAND_FWD_EN
    input  logic [DEPTH_LOG-1:0] q0_tag,
    output logic                 q0_hit,
    output logic [XLEN-1:0]      q0_value,
    input  logic [DEPTH_LOG-1:0] q1_tag,
    output logic                 q1_hit,
    output logic [XLEN-1:0]      q1_value,
`endif
    output logic                 empty,
    output logic                 full,
    output logic [DEPTH_LOG:0]   count
);

    localparam int DEPTH = 2 ** DEPTH_LOG;
    localparam int PW    = DEPTH_LOG + 1;

    typedef enum logic {
        IDLE,
        ST_WAIT
    } state_t;

    state_t state, state_nxt;

    logic [PW-1:0]        head, tail, cnt;
    logic [DEPTH_LOG-1:0] head_idx, tail_idx;
    logic [DEPTH-1:0]     done_q, is_st_q;
    logic [REG_W-1:0]     rd_q   [DEPTH];
    logic [XLEN-1:0]      val_q  [DEPTH];
    logic [XLEN-1:0]      addr_q [DEPTH];

    logic [DEPTH_LOG-1:0] wb_off, f_off;
    logic wb_live, wb_kill, wb_ok;
    logic flush_cut, alloc_ok, head_done;
    logic do_commit, do_st_issue, do_st_done, head_inc;

    assign head_idx    = head[DEPTH_LOG-1:0];
    assign tail_idx    = tail[DEPTH_LOG-1:0];
    assign cnt         = tail - head;
    assign count       = cnt;
    assign empty       = (cnt == '0);
    assign full        = (cnt == PW'(DEPTH));
    assign alloc_ready = !full;
    assign alloc_tag   = tail_idx;

    // Liveness is judged by distance from head, which sidesteps wrap cases.
    assign wb_off    = wb_tag - head_idx;
    assign wb_live   = {1'b0, wb_off} < cnt;
    assign f_off     = flush_tag - head_idx;
    assign flush_cut = flush && (f_off != '0) && ({1'b0, f_off} < cnt);
    assign wb_kill   = flush_cut && (wb_off >= f_off);
    assign wb_ok     = wb_valid && wb_live && !wb_kill;
    assign alloc_ok  = alloc_valid && !full && !flush;
    assign head_done = !empty && done_q[head_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (rdy) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        do_commit   = 1'b0;
        do_st_issue = 1'b0;
        do_st_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (head_done) begin
                    if (is_st_q[head_idx]) begin
                        do_st_issue = 1'b1;
                        state_nxt   = ST_WAIT;
                    end else begin
                        do_commit = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (st_ack) begin
                    do_st_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign head_inc = do_commit || do_st_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            head   <= '0;
            tail   <= '0;
            done_q <= '0;
        end else if (rdy) begin
            if (head_inc) begin
                head <= head + PW'(1);
            end
            // Truncation rebuilds the wrap bit from head so flush_tag lands in (head, tail].
            if (flush_cut) begin
                tail <= head + {1'b0, f_off};
            end else if (alloc_ok) begin
                tail <= tail + PW'(1);
            end
            if (alloc_ok) begin
                done_q[tail_idx] <= 1'b0;
            end
            if (wb_ok) begin
                done_q[wb_tag] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy) begin
            if (alloc_ok) begin
                rd_q[tail_idx]    <= alloc_rd;
                is_st_q[tail_idx] <= alloc_is_st;
            end
            if (wb_ok) begin
                val_q[wb_tag] <= wb_value;
                if (is_st_q[wb_tag]) begin
                    addr_q[wb_tag] <= wb_addr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            commit_valid <= 1'b0;
            commit_rd    <= '0;
            commit_value <= '0;
            commit_tag   <= '0;
            st_req       <= 1'b0;
            st_addr      <= '0;
            st_data      <= '0;
        end else if (!rdy) begin
            commit_valid <= 1'b0;
        end else begin
            commit_valid <= do_commit;
            if (do_commit) begin
                commit_rd    <= rd_q[head_idx];
                commit_value <= val_q[head_idx];
                commit_tag   <= head_idx;
            end
            if (do_st_issue) begin
                st_req  <= 1'b1;
                st_addr <= addr_q[head_idx];
                st_data <= val_q[head_idx];
            end else if (do_st_done) begin
                st_req <= 1'b0;
            end
        end
    end

`ifdef ROB_OPERAND_FWD_EN
    logic [DEPTH_LOG-1:0] q0_off, q1_off;
    logic q0_byp, q1_byp;

    // A same-cycle accepted writeback bypasses the entry array.
    assign q0_off   = q0_tag - head_idx;
    assign q1_off   = q1_tag - head_idx;
    assign q0_byp   = wb_ok && (wb_tag == q0_tag);
    assign q1_byp   = wb_ok && (wb_tag == q1_tag);
    assign q0_hit   = q0_byp || (({1'b0, q0_off} < cnt) && done_q[q0_tag]);
    assign q1_hit   = q1_byp || (({1'b0, q1_off} < cnt) && done_q[q1_tag]);
    assign q0_value = q0_byp ? wb_value : val_q[q0_tag];
    assign q1_value = q1_byp ? wb_value : val_q[q1_tag];
`else
    // Consumers pick up operands from the commit broadcast only.
`endif

endmodule
